// File: rtl/ntt_stage_scheduler_if.sv
// Issue/write-back bus between the NTT stage scheduler and the butterfly datapath.
// NTT_SCHED_HOLD_EN adds the hold input that stalls butterfly issue.
interface ntt_stage_scheduler_if #(
  parameter int unsigned LOG_N = 8
);
  localparam int unsigned SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  logic             start;
`ifdef NTT_SCHED_HOLD_EN
  logic             hold;
`endif
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rdEn;
  logic [LOG_N-1:0] rdAddrA;
  logic [LOG_N-1:0] rdAddrB;
  logic [LOG_N-2:0] twiddleIdx;
  logic             wrEn;
  logic [LOG_N-1:0] wrAddrA;
  logic [LOG_N-1:0] wrAddrB;

  modport master (
`ifdef NTT_SCHED_HOLD_EN
    input  hold,
`endif
    input  start,
    output busy, done, stage,
    output rdEn, rdAddrA, rdAddrB, twiddleIdx,
    output wrEn, wrAddrA, wrAddrB
  );

  modport slave (
`ifdef NTT_SCHED_HOLD_EN
    output hold,
`endif
    output start,
    input  busy, done, stage,
    input  rdEn, rdAddrA, rdAddrB, twiddleIdx,
    input  wrEn, wrAddrA, wrAddrB
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// In-place radix-2 NTT sequencer: issues one butterfly per cycle over LOG_N stages,
// drains the modelled datapath between stages. NTT_SCHED_HOLD_EN enables issue hold.
module ntt_stage_scheduler #(
  parameter int unsigned LOG_N  = 8,
  parameter int unsigned BF_LAT = 3
) (
  input logic                   clk,
  input logic                   rst,
  ntt_stage_scheduler_if.master bus
);
  localparam int unsigned SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int unsigned BW = LOG_N - 1;
  localparam int unsigned CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SW-1:0] LAST_S = SW'(LOG_N - 1);
  localparam logic [BW-1:0] LAST_B = '1;
  localparam logic [CW-1:0] LAST_C = CW'(BF_LAT - 1);

  logic hold_w;
`ifdef NTT_SCHED_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [BW-1:0]    b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_a_q, rd_a_d;
  logic [LOG_N-1:0] rd_b_q, rd_b_d;
  logic [BW-1:0]    tw_q, tw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BF_LAT-1:0] dv_q, dv_d;
  logic [LOG_N-1:0] da_q [BF_LAT];
  logic [LOG_N-1:0] da_d [BF_LAT];
  logic [LOG_N-1:0] db_q [BF_LAT];
  logic [LOG_N-1:0] db_d [BF_LAT];

  logic             issue;
  logic [LOG_N-1:0] bx, half, lo, a_lin;

  // b_q/s_q always describe the butterfly on the outputs, so issue decisions use next values.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          s_d     = '0;
          b_d     = '0;
          issue   = 1'b1;
        end
      end
      S_READ: begin
        if (!hold_w) begin
          if (b_q == LAST_B) begin
            state_d = S_DRAIN;
            b_d     = '0;
            cnt_d   = '0;
          end else begin
            b_d   = b_q + BW'(1);
            issue = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_C) begin
          if (s_q != LAST_S) begin
            state_d = S_READ;
            s_d     = s_q + SW'(1);
            issue   = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        s_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Insert a zero at bit s of b to form the top operand address.
    bx      = {1'b0, b_d};
    half    = LOG_N'(1) << s_d;
    lo      = bx & (half - LOG_N'(1));
    a_lin   = (((bx >> s_d) << s_d) << 1) | lo;
    rd_en_d = issue;
    rd_a_d  = issue ? a_lin : '0;
    rd_b_d  = issue ? (a_lin | half) : '0;
    tw_d    = issue ? (lo[BW-1:0] << (LAST_S - s_d)) : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);

    dv_d[0] = rd_en_q;
    da_d[0] = rd_a_q;
    db_d[0] = rd_b_q;
    for (int unsigned i = 1; i < BF_LAT; i++) begin
      dv_d[i] = dv_q[i-1];
      da_d[i] = da_q[i-1];
      db_d[i] = db_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dv_q    <= '0;
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        da_q[i] <= '0;
        db_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        da_q[i] <= da_d[i];
        db_q[i] <= db_d[i];
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stage      = s_q;
  assign bus.rdEn       = rd_en_q;
  assign bus.rdAddrA    = rd_a_q;
  assign bus.rdAddrB    = rd_b_q;
  assign bus.twiddleIdx = tw_q;
  assign bus.wrEn       = dv_q[BF_LAT-1];
  assign bus.wrAddrA    = da_q[BF_LAT-1];
  assign bus.wrAddrB    = db_q[BF_LAT-1];
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Scoreboard bench for ntt_stage_scheduler at LOG_N=8, BF_LAT=3.
module tb_ntt_stage_scheduler;
  typedef struct { int cyc; int stg; int a; int b; int tw; } rd_t;
  typedef struct { int cyc; int a; int b; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ecnt = 0;
  int   t0 = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   rd_seen, wr_seen, done_seen;
  int   hold_lo = -1, hold_hi = -2;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];
  rd_t hand_q[$];

  ntt_stage_scheduler_if #(.LOG_N(8)) bus ();

  ntt_stage_scheduler #(.LOG_N(8), .BF_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected issue order; operand address built by splitting b around bit s.
  task automatic push_transform(input int hold_len);
    for (int s = 0; s < 8; s++) begin
      int half = 1 << s;
      for (int b = 0; b < 128; b++) begin
        rd_t r;
        wr_t w;
        int lo = b % half;
        int hi = b / half;
        r.stg = s;
        r.a   = hi * 2 * half + lo;
        r.b   = r.a + half;
        r.tw  = lo * (128 / half);
        r.cyc = 1 + s * 131 + b + (((s > 3) || (s == 3 && b >= 40)) ? hold_len : 0);
        rd_q.push_back(r);
        w.cyc = r.cyc + 3;
        w.a   = r.a;
        w.b   = r.b;
        wr_q.push_back(w);
      end
    end
    done_q.push_back(1049 + hold_len);
  endtask

  int  mcyc;
  rd_t mr;
  wr_t mw;
  int  md;
  always @(negedge clk) begin
    if (mon_en) begin
      mcyc = ecnt - t0;
      if (bus.rdEn) begin
        rd_seen++;
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          mr = rd_q.pop_front();
          chk("rd_cycle", mcyc, mr.cyc);
          chk("rd_stage", int'(bus.stage), mr.stg);
          chk("rdAddrA", int'(bus.rdAddrA), mr.a);
          chk("rdAddrB", int'(bus.rdAddrB), mr.b);
          chk("twiddleIdx", int'(bus.twiddleIdx), mr.tw);
        end
      end
      if (bus.wrEn) begin
        wr_seen++;
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          mw = wr_q.pop_front();
          chk("wr_cycle", mcyc, mw.cyc);
          chk("wrAddrA", int'(bus.wrAddrA), mw.a);
          chk("wrAddrB", int'(bus.wrAddrB), mw.b);
        end
      end
      if (bus.done) begin
        done_seen++;
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          md = done_q.pop_front();
          chk("done_cycle", mcyc, md);
        end
      end
      if (hand_q.size() > 0 && hand_q[0].cyc == mcyc) begin
        mr = hand_q.pop_front();
        chk("hand_rdEn", int'(bus.rdEn), 1);
        chk("hand_stage", int'(bus.stage), mr.stg);
        chk("hand_rdAddrA", int'(bus.rdAddrA), mr.a);
        chk("hand_rdAddrB", int'(bus.rdAddrB), mr.b);
        chk("hand_twiddle", int'(bus.twiddleIdx), mr.tw);
      end
      if (mcyc >= hold_lo && mcyc <= hold_hi) chk("rdEn_while_hold", int'(bus.rdEn), 0);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_stage"}, int'(bus.stage), 0);
    chk({tag, "_rdEn"}, int'(bus.rdEn), 0);
    chk({tag, "_rdAddrA"}, int'(bus.rdAddrA), 0);
    chk({tag, "_rdAddrB"}, int'(bus.rdAddrB), 0);
    chk({tag, "_twiddle"}, int'(bus.twiddleIdx), 0);
    chk({tag, "_wrEn"}, int'(bus.wrEn), 0);
    chk({tag, "_wrAddrA"}, int'(bus.wrAddrA), 0);
    chk({tag, "_wrAddrB"}, int'(bus.wrAddrB), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    bus.start = 1'b1;
    t0 = ecnt;
    mon_en = 1'b1;
    @(negedge clk);
    chk("busy_cycle0", int'(bus.busy), 0);
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_cycle1", int'(bus.busy), 1);
  endtask

  task automatic run_transform(input bit extras);
    int hl = 0;
    int cyc;
`ifdef NTT_SCHED_HOLD_EN
    if (extras) hl = 10;
`endif
    rd_seen = 0; wr_seen = 0; done_seen = 0;
    push_transform(hl);
    if (extras) begin
      hand_q.push_back(rd_t'{1, 0, 0, 1, 0});
      hand_q.push_back(rd_t'{2, 0, 2, 3, 0});
      hand_q.push_back(rd_t'{268, 2, 9, 13, 32});
      hand_q.push_back(rd_t'{1045 + hl, 7, 127, 255, 127});
    end
    if (hl > 0) begin hold_lo = 434; hold_hi = 443; end
    else begin hold_lo = -1; hold_hi = -2; end
    pulse_start();
    for (int k = 0; k < 1300 && done_q.size() > 0; k++) begin
      @(posedge clk); #2;
      cyc = ecnt - t0;
      bus.start = (extras && cyc == 500);
`ifdef NTT_SCHED_HOLD_EN
      bus.hold = (hl > 0 && cyc >= 433 && cyc <= 442);
`endif
    end
    bus.start = 1'b0;
    chk("done_timeout", done_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("stage_after_done", int'(bus.stage), 0);
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("hand_left", hand_q.size(), 0);
    chk("rd_total", rd_seen, 1024);
    chk("wr_total", wr_seen, 1024);
    chk("done_total", done_seen, 1);
    hold_lo = -1; hold_hi = -2;
  endtask

  task automatic run_abort();
    int wr_after = 0;
    push_transform(0);
    pulse_start();
    while (ecnt - t0 < 300) begin
      @(posedge clk); #2;
    end
    rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    #1;
    check_all_zero("abort");
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.wrEn) wr_after++;
    end
    chk("wrEn_after_release", wr_after, 0);
    chk("busy_after_release", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef NTT_SCHED_HOLD_EN
    bus.hold = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    run_transform(1'b1);
    run_abort();
    run_transform(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ntt_stage_scheduler.md
Name: ntt_stage_scheduler

Overview:
Top-level sequencer for the in-place radix-2 NTT engine. On a start pulse it walks all LOG_N stages and issues one butterfly per cycle: read-port address pair, twiddle index and read enable. It delays each issued pair through a model of the butterfly pipeline to produce matching write-back addresses and write enable. Between stages it drains the pipeline so the next stage never reads stale data, then signals done.

Parameters:
LOG_N, 8, log2 of transform size N (N=256 by default)
BF_LAT, 3, butterfly datapath latency in cycles from rdEn to wrEn (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to run a full transform
busy  output  1  high whenever not IDLE
done  output  1  one-cycle pulse when the transform completes
stage  output  clog2(LOG_N)  current stage index s
rdEn  output  1  butterfly issue strobe
rdAddrA  output  LOG_N  butterfly top operand address
rdAddrB  output  LOG_N  butterfly bottom operand address
twiddleIdx  output  LOG_N-1  twiddle ROM index
wrEn  output  1  write-back strobe
wrAddrA  output  LOG_N  write address for result A
wrAddrB  output  LOG_N  write address for result B

Behaviour:
- rst low (async): state=IDLE; all counters, outputs and delay-line valid bits cleared; busy=0, done=0, rdEn=0, wrEn=0, all addresses 0.
- States: IDLE, READ, DRAIN, DONE. busy = (state != IDLE).
- IDLE: start=1 at an edge -> READ next cycle, s=0, b=0. start in any other state is ignored.
- READ: rdEn=1 every cycle. Butterfly counter b runs 0..N/2-1 and half = 2^s.
  - rdAddrA = ((b>>s)<<(s+1)) | (b & (half-1)).
  - rdAddrB = rdAddrA + half.
  - twiddleIdx = (b & (half-1)) << (LOG_N-1-s).
  - When b = N/2-1: go to DRAIN next cycle and reset b to 0.
- DRAIN: rdEn=0 for exactly BF_LAT cycles, then:
  - if s < LOG_N-1: increment s and return to READ;
  - otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE. stage holds LOG_N-1 until IDLE, then returns to 0.
- Write path: a BF_LAT-deep shift register carries {valid, rdAddrA, rdAddrB}. wrEn/wrAddrA/wrAddrB equal rdEn/rdAddrA/rdAddrB from exactly BF_LAT cycles earlier. The last write of each stage lands in the final DRAIN cycle.
- Timing at defaults: READ phase = 128 cycles; each stage = 131 cycles. If start is sampled at edge 0, done is high in cycle 1049 (8*131 + 1).
- All outputs are registered. Address arithmetic is modulo 2^LOG_N and no wrap beyond N-1 occurs.
- Reset asserted mid-operation aborts immediately: no done pulse, pipeline valids flushed, so no spurious wrEn after reset release.

Optional Feature:
Macro NTT_SCHED_HOLD_EN.
- Defined: adds input `hold` (1 bit).
  - When hold=1 in READ, no butterfly issues: rdEn=0, b and s frozen.
  - The delay line keeps shifting, so in-flight writes still complete.
  - hold is ignored in IDLE, DRAIN and DONE.
- Undefined: no hold port; READ issues unconditionally every cycle.

Test Plan:
- Reset, then a single start pulse -> busy=1 the next cycle; 1024 total rdEn cycles and 1024 total wrEn cycles; done pulses exactly once in cycle 1049; busy=0 afterwards.
- Stage 0 -> b=0: A=0, B=1, tw=0; b=1: A=2, B=3, tw=0. Stage 2, b=5 -> A=9, B=13, tw=32. Stage 7, b=127 -> A=127, B=255, tw=127.
- Check every wrEn cycle -> wrAddrA/wrAddrB equal the rdAddrA/rdAddrB issued BF_LAT=3 cycles earlier; rdEn and wrEn are never high together across a stage boundary.
- Pulse start again at cycle 500 while busy -> ignored; stage sequence and done timing unchanged.
- Assert rst low at cycle 300 for 2 cycles -> all outputs 0 immediately; no wrEn after release; a subsequent start runs a clean full transform.
- With NTT_SCHED_HOLD_EN, hold=1 for 10 cycles at stage 3, b=40 -> rdEn=0 while held; b resumes at 40; done is delayed by exactly 10 cycles.
